// File: rtl/use_record_collector.sv
// Round-robin collector: captures completed records from the StreamElement array in token
// order, pulses useTaken for the captured element, and serialises the record as AXI-Stream beats.
module use_record_collector #(
    parameter int NUM_ELEMENTS           = 4,
    parameter int DATA_BUS_WIDTH_BYTES   = 8,
    parameter int MAX_UNCOMPRESSED_BYTES = 34,
    parameter int LEN_W                  = $clog2(MAX_UNCOMPRESSED_BYTES)
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic [NUM_ELEMENTS-1:0][MAX_UNCOMPRESSED_BYTES-1:0][7:0] useStreamIn,
    input  logic [NUM_ELEMENTS-1:0][LEN_W-1:0]                     useLengthIn,
    output logic [NUM_ELEMENTS-1:0]                                useTaken,
    output logic [DATA_BUS_WIDTH_BYTES*8-1:0]                      m_axis_tdata,
    output logic [DATA_BUS_WIDTH_BYTES-1:0]                        m_axis_tkeep,
    output logic                                                   m_axis_tlast,
    output logic                                                   m_axis_tvalid,
    input  logic                                                   m_axis_tready,
    output logic [31:0]                                            recordCount,
    output logic                                                   lengthError
);

    localparam int W        = DATA_BUS_WIDTH_BYTES;
    localparam int CW       = LEN_W + 1;
    localparam int PTR_W    = $clog2(NUM_ELEMENTS);
    localparam int BUF_BITS = MAX_UNCOMPRESSED_BYTES * 8;

    localparam logic [CW-1:0]    W_C      = CW'(W);
    localparam logic [CW-1:0]    MAX_C    = CW'(MAX_UNCOMPRESSED_BYTES);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_ELEMENTS - 1);

    typedef enum logic {
        WAIT,
        EMIT
    } state_t;

    state_t                  state_reg, state_next;
    logic [PTR_W-1:0]        ptr_reg;
    logic [BUF_BITS-1:0]     buf_reg;
    logic [CW-1:0]           remaining_reg;
    logic [CW-1:0]           offset_reg;
    logic [NUM_ELEMENTS-1:0] taken_reg;
    logic [31:0]             count_reg;
    logic                    error_reg;

    logic [CW-1:0]           cur_len;
    logic                    capture;
    logic                    beat_fire;
    logic                    last_fire;
    logic [W*8-1:0]          window;

    // Only the element under the pointer is ever looked at; this preserves token order.
    assign cur_len = {1'b0, useLengthIn[ptr_reg]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= WAIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        beat_fire  = 1'b0;
        last_fire  = 1'b0;
        case (state_reg)
            WAIT: begin
                if (cur_len != '0) begin
                    capture    = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (m_axis_tready) begin
                    beat_fire = 1'b1;
                    if (m_axis_tlast) begin
                        last_fire  = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            default: state_next = WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg       <= '0;
            buf_reg       <= '0;
            remaining_reg <= '0;
            offset_reg    <= '0;
            taken_reg     <= '0;
            count_reg     <= '0;
            error_reg     <= 1'b0;
        end else begin
            taken_reg <= '0;
            if (capture) begin
                buf_reg    <= useStreamIn[ptr_reg];
                offset_reg <= '0;
                taken_reg  <= NUM_ELEMENTS'(1) << ptr_reg;
                ptr_reg    <= (ptr_reg == LAST_PTR) ? '0 : ptr_reg + PTR_W'(1);
                // Oversized lengths are clamped to the buffer and flagged, never emitted past it.
                if (cur_len > MAX_C) begin
                    remaining_reg <= MAX_C;
                    error_reg     <= 1'b1;
                end else begin
                    remaining_reg <= cur_len;
                end
            end
            if (beat_fire) begin
                offset_reg    <= offset_reg + W_C;
                remaining_reg <= last_fire ? '0 : remaining_reg - W_C;
            end
            if (last_fire) begin
                count_reg <= count_reg + 32'd1;
            end
        end
    end

    // Shifting the whole buffer makes any byte past the end read as zero.
    assign window = (W*8)'(buf_reg >> {offset_reg, 3'b000});

    assign m_axis_tvalid = (state_reg == EMIT);
    assign m_axis_tlast  = m_axis_tvalid && (remaining_reg <= W_C);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_lane
            localparam logic [CW-1:0] LANE = CW'(gi);
            logic lane_on;
            assign lane_on                 = m_axis_tvalid && (remaining_reg > LANE);
            assign m_axis_tkeep[gi]        = lane_on;
            assign m_axis_tdata[gi*8 +: 8] = lane_on ? window[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    assign useTaken    = taken_reg;
    assign recordCount = count_reg;
    assign lengthError = error_reg;

endmodule

// File: tb/tb_use_record_collector.sv
// Bench for use_record_collector: directed scenarios plus random records and random
// backpressure, checked against a record-level scoreboard of expected beats and taken pulses.
module tb_use_record_collector;

    localparam int NE   = 4;
    localparam int W    = 8;
    localparam int MAXB = 34;
    localparam int LW   = $clog2(MAXB);

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        int elem;
        bit big;
    } tk_t;

    logic                            clk;
    logic                            reset;
    logic [NE-1:0][MAXB-1:0][7:0]    stream_in;
    logic [NE-1:0][LW-1:0]           length_in;
    logic [NE-1:0]                   use_taken;
    logic [W*8-1:0]                  tdata;
    logic [W-1:0]                    tkeep;
    logic                            tlast;
    logic                            tvalid;
    logic                            tready;
    logic [31:0]                     record_count;
    logic                            length_error;

    use_record_collector #(
        .NUM_ELEMENTS(NE),
        .DATA_BUS_WIDTH_BYTES(W),
        .MAX_UNCOMPRESSED_BYTES(MAXB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .useStreamIn(stream_in),
        .useLengthIn(length_in),
        .useTaken(use_taken),
        .m_axis_tdata(tdata),
        .m_axis_tkeep(tkeep),
        .m_axis_tlast(tlast),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .recordCount(record_count),
        .lengthError(length_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      n_assert = 0;
    int      n_fail   = 0;
    beat_t   exp_q[$];
    tk_t     taken_q[$];
    int      exp_count = 0;
    bit      exp_err = 0;
    int      next_load = 0;
    logic [NE-1:0] pending_clear = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Expected beats derived from the record bytes: W bytes per beat, low-aligned, clamped to MAXB.
    task automatic push_rec(input int e);
        int len;
        int eff;
        int n;
        beat_t bt;
        len = int'(length_in[e]);
        eff = (len > MAXB) ? MAXB : len;
        for (int off = 0; off < eff; off += W) begin
            n = ((eff - off) > W) ? W : (eff - off);
            bt.data = '0;
            bt.keep = '0;
            for (int k = 0; k < n; k++) begin
                bt.data[k*8 +: 8] = stream_in[e][off+k];
                bt.keep[k]        = 1'b1;
            end
            bt.last = (off + W >= eff);
            exp_q.push_back(bt);
        end
        taken_q.push_back('{e, (len > MAXB)});
    endtask

    task automatic load(input int e, input int len, input bit seq, input bit push);
        for (int b = 0; b < MAXB; b++) begin
            stream_in[e][b] = (seq && b < len) ? 8'(b) : 8'($urandom);
        end
        length_in[e] = LW'(len);
        if (push) push_rec(e);
    endtask

    task automatic load_next(input int len, input bit seq);
        load(next_load, len, seq, 1'b1);
        next_load = (next_load + 1) % NE;
    endtask

    // One clock: score the beat presented now, advance, then check taken/count/error.
    task automatic step();
        bit    last_acc;
        beat_t e;
        last_acc = 1'b0;
        if (tvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_tvalid", 64'(tvalid), 64'd0);
            end else begin
                e = exp_q[0];
                chk("tdata", 64'(tdata), e.data);
                chk("tkeep", 64'(tkeep), 64'(e.keep));
                chk("tlast", 64'(tlast), 64'(e.last));
                if (tready) begin
                    void'(exp_q.pop_front());
                    last_acc = e.last;
                end
            end
        end
        @(posedge clk);
        #1;
        if (last_acc) exp_count++;
        for (int i = 0; i < NE; i++) begin
            if (pending_clear[i]) length_in[i] = '0;
        end
        pending_clear = '0;
        if (use_taken !== '0) begin
            if (taken_q.size() == 0) begin
                chk("taken_unexpected", 64'(use_taken), 64'd0);
            end else begin
                chk("taken_onehot", 64'(use_taken), 64'd1 << taken_q[0].elem);
                if (taken_q[0].big) exp_err = 1'b1;
                void'(taken_q.pop_front());
            end
            pending_clear = use_taken;
        end
        chk("recordCount", 64'(record_count), 64'(exp_count));
        chk("lengthError", 64'(length_error), 64'(exp_err));
    endtask

    task automatic drain(input int budget, input int ready_pct);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || taken_q.size() != 0) && n < budget) begin
            tready = ($urandom_range(99) < ready_pct);
            step();
            n++;
        end
        tready = 1'b1;
        step();
        chk("drain_beats_left", 64'(exp_q.size()), 64'd0);
        chk("drain_taken_left", 64'(taken_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        length_in = '0;
        @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_tkeep", 64'(tkeep), 64'd0);
        chk("rst_tdata", 64'(tdata), 64'd0);
        chk("rst_taken", 64'(use_taken), 64'd0);
        chk("rst_count", 64'(record_count), 64'd0);
        chk("rst_error", 64'(length_error), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        taken_q.delete();
        exp_count = 0;
        exp_err = 1'b0;
        next_load = 0;
        pending_clear = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int loaded;
        int cyc;
        reset     = 1'b1;
        stream_in = '0;
        length_in = '0;
        tready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Record of 17 sequential bytes: three beats, first beat one clock after capture.
        load_next(17, 1'b1);
        step();
        chk("t1_first_beat_latency", 64'(tvalid), 64'd1);
        drain(50, 100);
        chk("t1_count", 64'(record_count), 64'd1);

        // Exactly two full beats, no trailing empty beat.
        load_next(16, 1'b0);
        drain(50, 100);
        chk("t2_count", 64'(record_count), 64'd2);

        // All elements full at once: consumed 0,1,2,3 and the pointer wraps.
        do_reset();
        for (int i = 0; i < NE; i++) load_next(9, 1'b0);
        drain(100, 100);
        chk("t3_count", 64'(record_count), 64'd4);

        // Element 1 ready while pointer sits on empty element 0: nothing may happen.
        load(1, 20, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_idle_tvalid", 64'(tvalid), 64'd0);
            chk("t4_idle_taken", 64'(use_taken), 64'd0);
        end
        load(0, 12, 1'b0, 1'b0);
        push_rec(0);
        push_rec(1);
        next_load = 2;
        drain(100, 100);

        // Backpressure 1,0,0,1 mid-record: held beat rechecked every stalled cycle.
        load_next(30, 1'b0);
        step();
        for (int i = 0; i < 8; i++) begin
            tready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        drain(100, 100);

        // Random records and random backpressure, elements refilled as soon as they clear.
        loaded = 0;
        cyc = 0;
        while (loaded < 40 && cyc < 5000) begin
            if (length_in[next_load] == '0 && !pending_clear[next_load] && $urandom_range(1) == 1) begin
                load_next(int'($urandom_range(1, 40)), 1'b0);
                loaded++;
            end
            tready = ($urandom_range(3) != 0);
            step();
            cyc++;
        end
        chk("rand_all_loaded", 64'(loaded), 64'd40);
        drain(2000, 70);

        // Oversized length: clamped to 34 bytes and flagged.
        load_next(40, 1'b1);
        drain(50, 100);
        chk("t6_length_error", 64'(length_error), 64'd1);

        // Reset in the middle of a record drops it.
        load_next(30, 1'b0);
        step();
        tready = 1'b1;
        step();
        chk("t6_mid_emit_valid", 64'(tvalid), 64'd1);
        do_reset();
        step();
        chk("t6_after_reset_valid", 64'(tvalid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
